// File: rtl/hash_tx_pkg.sv
// hash_tx_pkg: state encoding and frame constants shared by the hash transmit framer.
package hash_tx_pkg;

    localparam int          LEN_W     = 11;
    localparam int          HDR_BYTES = 4;
    localparam logic [15:0] SYNC_WORD = 16'hA55A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_LEN_H,
        ST_LEN_L,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DONE
    } tx_state_e;

endpackage

// File: rtl/hash_tx_skid.sv
// hash_tx_skid: 2-entry byte buffer between the hash FIFO and the output register.
// Tracks reads still in flight so the framer never requests more than it can hold.
module hash_tx_skid (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rd_en,
    input  logic       fifo_valid,
    input  logic [7:0] fifo_data,
    input  logic       pop,
    output logic       avail,
    output logic [7:0] head,
    output logic [1:0] occupancy,
    output logic [1:0] outstanding
);

    logic [1:0][7:0] mem_q, mem_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      occ_q, occ_d;
    logic [1:0]      out_q, out_d;
    logic            push, store, take;

    always_comb begin
        push  = fifo_valid && (out_q != 2'd0);
        take  = pop && (occ_q != 2'd0);
        // An arriving byte popped straight through an empty buffer is never stored.
        store = push && !(pop && (occ_q == 2'd0));
        avail = (occ_q != 2'd0) || push;
        head  = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : fifo_data;

        mem_d = mem_q;
        if (store) begin
            mem_d[wr_ptr_q] = fifo_data;
        end
        wr_ptr_d = wr_ptr_q ^ store;
        rd_ptr_d = rd_ptr_q ^ take;
        occ_d    = occ_q + {1'b0, store} - {1'b0, take};
        out_d    = out_q + {1'b0, rd_en} - {1'b0, push};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            out_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            out_q    <= out_d;
        end
    end

    assign occupancy   = occ_q;
    assign outstanding = out_q;

endmodule

// File: rtl/hash_tx.sv
// hash_tx: frames hash FIFO bytes as sync word, 11-bit length, payload and optional checksum.
// Define HASH_TX_CSUM_EN to append the two's-complement checksum byte after the payload.
module hash_tx
    import hash_tx_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             txStart,
    input  logic [LEN_W-1:0] txByteTotal,
    input  logic [7:0]       hashDataIn,
    input  logic             hashFifoEmpty,
    input  logic             hashFifoValid,
    output logic             hashRdEn,
    output logic [7:0]       txData,
    output logic             txValid,
    input  logic             txReady,
    output logic             txLast,
    output logic             txBusy,
    output logic             txDone,
    output logic             txOverrun
);

    tx_state_e        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rd_req_cnt_q, rd_req_cnt_d;
    logic [LEN_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q, tx_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
`ifdef HASH_TX_CSUM_EN
    logic [7:0]       csum_q, csum_d;
    logic             load_csum;
`endif

    logic             xfer, pop, try_load, finish, avail;
    logic [7:0]       head;
    logic [1:0]       occupancy, outstanding;
    logic [2:0]       fill_level;

    hash_tx_skid u_skid (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_en       (hashRdEn),
        .fifo_valid  (hashFifoValid),
        .fifo_data   (hashDataIn),
        .pop         (pop),
        .avail       (avail),
        .head        (head),
        .occupancy   (occupancy),
        .outstanding (outstanding)
    );

    assign xfer       = tx_valid_q && txReady;
    assign fill_level = {1'b0, occupancy} + {1'b0, outstanding};

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rd_req_cnt_d = rd_req_cnt_q;
        tx_cnt_d     = tx_cnt_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        tx_last_d    = tx_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q;
        pop          = 1'b0;
        try_load     = 1'b0;
        finish       = 1'b0;
`ifdef HASH_TX_CSUM_EN
        csum_d       = csum_q;
        load_csum    = 1'b0;
`endif

        // Prefetch starts with the header so the payload follows LEN_L without a gap.
        hashRdEn = (state_q inside {ST_SYNC0, ST_SYNC1, ST_LEN_H, ST_LEN_L, ST_PAYLOAD})
                   && !hashFifoEmpty && (fill_level < 3'd2) && (rd_req_cnt_q < len_q);
        if (hashRdEn) begin
            rd_req_cnt_d = rd_req_cnt_q + 1'b1;
        end

        if (txStart && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (txStart) begin
                    len_d        = txByteTotal;
                    rd_req_cnt_d = '0;
                    tx_cnt_d     = '0;
                    tx_data_d    = SYNC_WORD[15:8];
                    tx_valid_d   = 1'b1;
                    tx_last_d    = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_SYNC0;
`ifdef HASH_TX_CSUM_EN
                    csum_d       = 8'h00;
`endif
                end
            end
            ST_SYNC0: begin
                if (xfer) begin
                    tx_data_d = SYNC_WORD[7:0];
                    state_d   = ST_SYNC1;
                end
            end
            ST_SYNC1: begin
                if (xfer) begin
                    tx_data_d = {5'b0, len_q[10:8]};
                    state_d   = ST_LEN_H;
`ifdef HASH_TX_CSUM_EN
                    csum_d    = csum_q + {5'b0, len_q[10:8]};
`endif
                end
            end
            ST_LEN_H: begin
                if (xfer) begin
                    tx_data_d = len_q[7:0];
                    state_d   = ST_LEN_L;
`ifdef HASH_TX_CSUM_EN
                    csum_d    = csum_q + len_q[7:0];
`else
                    tx_last_d = (len_q == '0);
`endif
                end
            end
            ST_LEN_L: begin
                if (xfer) begin
                    if (len_q != '0) begin
                        state_d  = ST_PAYLOAD;
                        try_load = 1'b1;
                    end else begin
`ifdef HASH_TX_CSUM_EN
                        load_csum = 1'b1;
`else
                        finish    = 1'b1;
`endif
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if ((tx_cnt_q + 1'b1) == len_q) begin
`ifdef HASH_TX_CSUM_EN
                        load_csum = 1'b1;
`else
                        finish    = 1'b1;
`endif
                    end else begin
                        try_load = 1'b1;
                    end
                end else if (!tx_valid_q) begin
                    try_load = 1'b1;
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    finish = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An empty buffer leaves txValid low; a presented byte is never withdrawn.
        if (try_load) begin
            if (avail) begin
                pop        = 1'b1;
                tx_data_d  = head;
                tx_valid_d = 1'b1;
`ifdef HASH_TX_CSUM_EN
                tx_last_d  = 1'b0;
                csum_d     = csum_d + head;
`else
                tx_last_d  = ((tx_cnt_d + 1'b1) == len_q);
`endif
            end else begin
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
            end
        end

`ifdef HASH_TX_CSUM_EN
        if (load_csum) begin
            state_d    = ST_CSUM;
            tx_data_d  = 8'h00 - csum_q;
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b1;
        end
`endif

        if (finish) begin
            state_d    = ST_DONE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            rd_req_cnt_q <= '0;
            tx_cnt_q     <= '0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef HASH_TX_CSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_req_cnt_q <= rd_req_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_last_q    <= tx_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
`ifdef HASH_TX_CSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign txData    = tx_data_q;
    assign txValid   = tx_valid_q;
    assign txLast    = tx_last_q;
    assign txBusy    = busy_q;
    assign txDone    = done_q;
    assign txOverrun = overrun_q;

endmodule

// File: tb/tb_hash_tx.sv
// tb_hash_tx: scoreboard bench for the hash transmit framer with a behavioural hash FIFO.
module tb_hash_tx;

`ifdef HASH_TX_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic        txStart;
    logic [10:0] txByteTotal;
    logic [7:0]  hashDataIn;
    logic        hashFifoEmpty;
    logic        hashFifoValid;
    logic        hashRdEn;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        txLast;
    logic        txBusy;
    logic        txDone;
    logic        txOverrun;

    hash_tx dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .txStart       (txStart),
        .txByteTotal   (txByteTotal),
        .hashDataIn    (hashDataIn),
        .hashFifoEmpty (hashFifoEmpty),
        .hashFifoValid (hashFifoValid),
        .hashRdEn      (hashRdEn),
        .txData        (txData),
        .txValid       (txValid),
        .txReady       (txReady),
        .txLast        (txLast),
        .txBusy        (txBusy),
        .txDone        (txDone),
        .txOverrun     (txOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] fifo[$];
    logic [8:0] sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0, xfers = 0, pay_xfers = 0, reads = 0, dones = 0, gaps = 0, max_held = 0;
    int first_cyc = 0, last_cyc = 0;
    bit toggle = 0, starve_mode = 0, starve_req = 0;
    int starve = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    logic prev_last = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        xfers = 0; pay_xfers = 0; reads = 0; dones = 0; gaps = 0; max_held = 0;
        first_cyc = 0; last_cyc = 0;
    endtask

    // Behavioural hash FIFO: data returns with hashFifoValid one cycle after a read.
    initial begin
        bit rd;
        hashFifoValid = 1'b0;
        hashDataIn    = 8'h00;
        hashFifoEmpty = 1'b1;
        forever begin
            @(negedge clk);
            rd = (hashRdEn === 1'b1) && !hashFifoEmpty;
            @(posedge clk);
            #1;
            hashFifoValid = rd && (fifo.size() > 0);
            if (hashFifoValid) hashDataIn = fifo.pop_front();
            if (starve_req) begin
                starve = 10;
                starve_req = 0;
            end else if (starve > 0) begin
                starve--;
            end
            hashFifoEmpty = (fifo.size() == 0) || (starve > 0);
        end
    end

    initial begin
        txReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            txReady = toggle ? ~txReady : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks stall stability.
    always @(negedge clk) begin
        logic [8:0] e;
        int held;
        cyc++;
        if (reset_n !== 1'b1) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", txValid, 1);
                chk("stall_data", txData, prev_data);
                chk("stall_last", txLast, prev_last);
            end
            if (hashRdEn && !hashFifoEmpty) reads++;
            if (txDone) dones++;
            if (txBusy && !txValid) gaps++;
            if (txValid && txReady) begin
                if (xfers == 0) first_cyc = cyc;
                last_cyc = cyc;
                xfers++;
                if (xfers > 4) pay_xfers++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_xfer: got byte %02h, expected no transfer", txData);
                end else begin
                    e = sb.pop_front();
                    chk("tx_data", txData, e[7:0]);
                    chk("tx_last", txLast, e[8]);
                end
                if (starve_mode && pay_xfers == 40) starve_req = 1;
            end
            held = reads - pay_xfers;
            if (held > max_held) max_held = held;
            prev_stall = txValid && !txReady;
            prev_data  = txData;
            prev_last  = txLast;
        end
    end

    task automatic load_fifo(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) fifo.push_back(8'(base + i));
    endtask

    task automatic expect_frame(input int len, input logic [7:0] base, input logic [7:0] csum);
        logic [10:0] l;
        l = 11'(len);
        sb.push_back({1'b0, 8'hA5});
        sb.push_back({1'b0, 8'h5A});
        sb.push_back({1'b0, 5'b0, l[10:8]});
        sb.push_back({(CS == 0 && len == 0), l[7:0]});
        for (int i = 0; i < len; i++) sb.push_back({(CS == 0 && i == len - 1), 8'(base + i)});
        if (CS == 1) sb.push_back({1'b1, csum});
    endtask

    task automatic start_frame(input int len);
        @(posedge clk);
        #1;
        txByteTotal = 11'(len);
        txStart = 1'b1;
        @(posedge clk);
        #1;
        txStart = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int nexp);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (txDone) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_timeout: got no txDone, expected one within 3000 cycles", tag);
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_sb_left"}, sb.size(), 0);
        chk({tag, "_xfers"}, xfers, nexp);
        chk({tag, "_busy_after"}, txBusy, 0);
    endtask

    task automatic wait_payload(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pay_xfers >= n) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rden"}, hashRdEn, 0);
        chk({tag, "_data"}, txData, 8'h00);
        chk({tag, "_valid"}, txValid, 0);
        chk({tag, "_last"}, txLast, 0);
        chk({tag, "_busy"}, txBusy, 0);
        chk({tag, "_done"}, txDone, 0);
        chk({tag, "_overrun"}, txOverrun, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        txStart = 1'b0;
        txByteTotal = 11'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 80-byte frame at full rate
        clear_stats();
        load_fifo(80, 8'h00);
        expect_frame(80, 8'h00, 8'h58);
        start_frame(80);
        chk("lat_busy", txBusy, 1);
        chk("lat_valid", txValid, 1);
        chk("lat_sync0", txData, 8'hA5);
        wait_done("full", 84 + CS);
        chk("full_consecutive", last_cyc - first_cyc + 1, 84 + CS);

        // Backpressure
        clear_stats();
        load_fifo(80, 8'h00);
        expect_frame(80, 8'h00, 8'h58);
        toggle = 1;
        start_frame(80);
        wait_done("bp", 84 + CS);
        toggle = 0;
        chk("bp_held_le3", (max_held <= 3) ? 1 : 0, 1);

        // FIFO underrun
        clear_stats();
        load_fifo(80, 8'h00);
        expect_frame(80, 8'h00, 8'h58);
        starve_mode = 1;
        start_frame(80);
        wait_done("under", 84 + CS);
        starve_mode = 0;
        chk("under_gap_seen", (gaps > 0) ? 1 : 0, 1);

        // Zero length
        clear_stats();
        load_fifo(4, 8'hEE);
        expect_frame(0, 8'h00, 8'h00);
        start_frame(0);
        wait_done("zero", 4 + CS);
        chk("zero_reads", reads, 0);
        fifo.delete();

        // Overrun
        clear_stats();
        load_fifo(28, 8'h80);
        expect_frame(20, 8'h80, 8'h2E);
        start_frame(20);
        wait_payload(5);
        txByteTotal = 11'd7;
        txStart = 1'b1;
        @(posedge clk);
        #1;
        txStart = 1'b0;
        wait_done("ovr", 24 + CS);
        chk("ovr_flag", txOverrun, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("ovr_sticky", txOverrun, 1);
        chk("ovr_no_second", xfers, 24 + CS);
        fifo.delete();

        // Reset mid-frame
        clear_stats();
        load_fifo(30, 8'hA0);
        expect_frame(30, 8'hA0, 8'h6F);
        start_frame(30);
        wait_payload(10);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fifo.delete();
        clear_stats();
        load_fifo(5, 8'hC0);
        expect_frame(5, 8'hC0, 8'h31);
        start_frame(5);
        wait_done("post", 9 + CS);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hash_tx.md
# hash_tx

Transmit-side framer for the hash pipeline. It consumes the 8-bit hash byte FIFO that the SHA-1 hash generator fills. On the generator's `txStart` pulse it reads `txByteTotal` bytes from that FIFO and emits one framed byte stream toward the MAC/UART transmitter over a valid/ready handshake. Each frame is sync word, 11-bit length, payload and an optional checksum.

## Interface
- `SYNC_WORD`, 16'hA55A: two-byte frame preamble, MSB first.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `txStart` in 1: one-cycle frame request.
- `txByteTotal` in 11: payload length; sampled with `txStart`.
- `hashDataIn` in 8: FIFO read data; valid when `hashFifoValid` is high.
- `hashFifoEmpty` in 1: FIFO empty flag.
- `hashFifoValid` in 1: read data valid, one cycle after `hashRdEn`.
- `hashRdEn` out 1: FIFO read strobe; one byte per asserted cycle.
- `txData` out 8: stream byte.
- `txValid` out 1: `txData` is valid.
- `txReady` in 1: sink accepts the byte; a transfer happens when `txValid & txReady`.
- `txLast` out 1: marks the final byte of the frame.
- `txBusy` out 1: high from `txStart` acceptance through the last transfer.
- `txDone` out 1: one-cycle pulse after the last transfer.
- `txOverrun` out 1: sticky; set when `txStart` arrives while busy.

## Operation
- States: IDLE, SYNC0, SYNC1, LEN_H, LEN_L, PAYLOAD, CSUM, DONE.
- IDLE → SYNC0 on `txStart`. The block latches `len = txByteTotal` and clears `rd_req_cnt`, `tx_cnt` and `csum`.
- Header states SYNC0/SYNC1/LEN_H/LEN_L send, in order:
  - `SYNC_WORD[15:8]`
  - `SYNC_WORD[7:0]`
  - `{5'b0, len[10:8]}`
  - `len[7:0]`
  - Each state advances on a transfer.
- LEN_L → PAYLOAD if `len != 0`; otherwise → CSUM, or DONE when checksum is compiled out.
- PAYLOAD:
  - Bytes are drained from a 2-entry skid buffer.
  - `hashRdEn = !hashFifoEmpty && (occupancy + outstanding) < 2 && rd_req_cnt < len`.
  - Each returned `hashFifoValid` byte is pushed into the buffer.
  - Leaves on the transfer of byte `len`.
- DONE: pulses `txDone` for one cycle and drops `txBusy` → IDLE.
- `txStart` is ignored outside IDLE (including DONE) and sets `txOverrun`. The current frame is unaffected.
- `hashFifoValid` with no outstanding read is ignored.
- Counters are 11 bits and cannot wrap, because reads stop at `len`.
- Checksum is an 8-bit modulo-256 sum of LEN_H, LEN_L and all payload bytes.

## Timing
- Reset values: `hashRdEn` 0, `txData` 8'h00, `txValid` 0, `txLast` 0, `txBusy` 0, `txDone` 0, `txOverrun` 0, state IDLE, skid buffer empty.
- `txStart` accepted at cycle 0 → `txBusy` = 1 and `txValid` = 1 with SYNC0 at cycle 1. All outputs are registered.
- While `txValid & !txReady`: `txData` and `txLast` are held stable and `txValid` stays high.
- `hashRdEn` at cycle t → data is in the buffer at t+1 and can be presented on `txData` at t+2.
- With the FIFO non-empty and `txReady` held high, payload runs at one byte per cycle.
- FIFO empty mid-payload: `txValid` deasserts only between transfers; it never retracts a byte already presented.
- `txDone` is asserted the cycle after the final transfer; `txStart` is accepted again the cycle after that.
- Reset asserted mid-frame: all state returns to reset values immediately. FIFO contents are not flushed. The next `txStart` starts a fresh frame from SYNC0.

## Configuration
- `HASH_TX_CSUM_EN` defined:
  - CSUM state is present and sends `8'h00 - csum`, so the sum of LEN_H..CSUM ≡ 0 mod 256.
  - `txLast` is on the CSUM byte.
- `HASH_TX_CSUM_EN` undefined:
  - No CSUM state and no checksum register.
  - `txLast` is on the final payload byte, or on LEN_L when `len == 0`.

## Structure
- Package `hash_tx_pkg`:
  - State enum.
  - Default `SYNC_WORD`.
  - `LEN_W = 11`.
  - Header byte count 4.
- Sub-module `hash_tx_skid`: 2-entry byte buffer with push/pop, occupancy, and outstanding-read counting.
- `hash_tx` itself holds the FSM, length/request counters, checksum and output registers.

## Test plan
- **80-byte frame.** FIFO preloaded with 0x00..0x4F, `txByteTotal` = 80, `txReady` = 1.
  - Stream is A5 5A 00 50 00..4F 58 (checksum enabled).
  - `txLast` is on 0x58 and `txDone` pulses once.
  - 85 transfers in consecutive cycles.
- **Backpressure.** Same frame with `txReady` toggling 1/0 each cycle.
  - Identical byte sequence, no byte lost or duplicated.
  - `txData` is stable while stalled.
  - Buffer occupancy plus outstanding reads never exceeds 2.
- **FIFO underrun.** `hashFifoEmpty` forced high for 10 cycles after payload byte 40.
  - `txValid` gaps only between transfers.
  - Frame completes correctly with 80 payload bytes.
- **Zero length.** `txByteTotal` = 0.
  - Stream is A5 5A 00 00 00, with `txLast` on the final 00.
  - `hashRdEn` is never asserted.
- **Overrun.** `txStart` re-pulsed during PAYLOAD.
  - `txOverrun` = 1 and stays high.
  - The in-flight frame is unchanged and no second frame is sent.
- **Reset mid-frame.** `reset_n` asserted during PAYLOAD.
  - All outputs go to reset values in the same cycle.
  - After release, `txStart` produces a frame starting at A5.
